// File: rtl/gaussian_pkg.sv
// Shared constants for the 3x3 Gaussian filter: pixel/sum widths, kernel weights,
// rounding and default frame geometry.
package gaussian_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned SUM_W = 12;

  localparam int unsigned IMG_W_DEF = 400;
  localparam int unsigned IMG_H_DEF = 300;

  // Kernel [1 2 1; 2 4 2; 1 2 1], total weight 16.
  localparam int unsigned K_CORNER = 1;
  localparam int unsigned K_EDGE   = 2;
  localparam int unsigned K_CENTRE = 4;

  localparam int unsigned RND   = 8;
  localparam int unsigned SHIFT = 4;

  function automatic logic [SUM_W-1:0] wtap(input logic [PIX_W-1:0] p, input int unsigned w);
    return SUM_W'(p) * SUM_W'(w);
  endfunction

endpackage

// File: rtl/gauss_line_buffer.sv
// One-line delay: each enabled cycle reads the pixel stored IMG_W pixels ago and
// overwrites it with the new one at the same address.
module gauss_line_buffer
  import gaussian_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_q;

  assign dout = mem[addr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (en) begin
      addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  // Contents are never cleared; border masking keeps stale data out of the output.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr_q] <= din;
    end
  end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// 3x3 Gaussian filter over a raster pixel stream with a 2-cycle output latency.
// Optional GAUSS_FRAME_MARKERS_EN adds sof_out/eol_out aligned with valid_out.
module gaussian_filter_3x3
  import gaussian_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             fifo_valid,
  input  logic [PIX_W-1:0] fifo_dout,
  output logic             valid_out,
  output logic [PIX_W-1:0] dout
`ifdef GAUSS_FRAME_MARKERS_EN
  ,
  output logic             sof_out,
  output logic             eol_out
`endif
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             last_col, last_row, in_win;

  logic [PIX_W-1:0] lb1_dout, lb2_dout;
  logic [PIX_W-1:0] col_in [3];
  logic [PIX_W-1:0] win_q  [3][3];

  logic [SUM_W-1:0] sum_d, sum_q, rnd;
  logic             v1_q, v2_q;
  logic [PIX_W-1:0] dout_q;

  assign fifo_rd_en = ~fifo_empty & ~rst;

  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));
  assign in_win   = fifo_valid && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (fifo_valid) begin
      col_q <= last_col ? '0 : col_q + COL_W'(1);
      if (last_col) begin
        row_q <= last_row ? '0 : row_q + ROW_W'(1);
      end
    end
  end

  gauss_line_buffer #(
    .DEPTH(IMG_W)
  ) u_lb1 (
    .clk (clk),
    .rst (rst),
    .en  (fifo_valid),
    .din (fifo_dout),
    .dout(lb1_dout)
  );

  gauss_line_buffer #(
    .DEPTH(IMG_W)
  ) u_lb2 (
    .clk (clk),
    .rst (rst),
    .en  (fifo_valid),
    .din (lb1_dout),
    .dout(lb2_dout)
  );

  // Incoming column, oldest row first: rows r-2, r-1, r.
  always_comb begin
    col_in[0] = lb2_dout;
    col_in[1] = lb1_dout;
    col_in[2] = fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (fifo_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
        win_q[i][2] <= col_in[i];
      end
    end
  end

  // Sum over the window as it will look after this pixel shifts in.
  always_comb begin
    sum_d = wtap(win_q[0][1], K_CORNER) + wtap(win_q[0][2], K_EDGE) + wtap(col_in[0], K_CORNER)
          + wtap(win_q[1][1], K_EDGE) + wtap(win_q[1][2], K_CENTRE) + wtap(col_in[1], K_EDGE)
          + wtap(win_q[2][1], K_CORNER) + wtap(win_q[2][2], K_EDGE) + wtap(col_in[2], K_CORNER);
  end

  assign rnd = sum_q + SUM_W'(RND);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      v1_q   <= 1'b0;
      dout_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= in_win;
      if (in_win) begin
        sum_q <= sum_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        dout_q <= PIX_W'(rnd >> SHIFT);
      end
    end
  end

  assign valid_out = v2_q & ~rst;
  assign dout      = dout_q & {PIX_W{~rst}};

`ifdef GAUSS_FRAME_MARKERS_EN
  logic sof1_q, eol1_q, sof2_q, eol2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
    end else begin
      sof1_q <= in_win && (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
      eol1_q <= in_win && last_col;
      sof2_q <= sof1_q;
      eol2_q <= eol1_q;
    end
  end

  assign sof_out = sof2_q & ~rst;
  assign eol_out = eol2_q & ~rst;
`endif

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// Self-checking bench for gaussian_filter_3x3: a FIFO emulator feeds frames and a
// 2-D convolution model predicts every strobe's value, centre and cycle.
module tb_gaussian_filter_3x3;

  localparam int unsigned W    = 20;
  localparam int unsigned H    = 10;
  localparam int          NOUT = (W - 2) * (H - 2);

  typedef struct {
    int val;
    int cyc;
    int r;
    int c;
    bit sof;
    bit eol;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       fifo_valid;
  logic [7:0] fifo_dout;
  logic       valid_out;
  logic [7:0] dout;
`ifdef GAUSS_FRAME_MARKERS_EN
  logic       sof_out;
  logic       eol_out;
`endif

  gaussian_filter_3x3 #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_valid(fifo_valid),
    .fifo_dout (fifo_dout),
    .valid_out (valid_out),
    .dout      (dout)
`ifdef GAUSS_FRAME_MARKERS_EN
    ,
    .sof_out   (sof_out),
    .eol_out   (eol_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp, n_fail;
  int   cyc, strobes, sof_cnt, eol_cnt, gap_pct;
  bit   pending, rst_prev;
  int   pix_q [$];
  exp_t exp_q [$];
  int   img [H][W];
  int   obs [H][W];
  int   mrow, mcol;
  int   kern [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

  // Reference: full 2-D convolution over the frame image as pixels arrive.
  task automatic model_accept(input int px);
    exp_t e;
    int   acc;
    img[mrow][mcol] = px;
    if (mrow >= 2 && mcol >= 2) begin
      acc = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += kern[i][j] * img[mrow - 2 + i][mcol - 2 + j];
      e.val = (acc + 8) / 16;
      e.cyc = cyc + 2;
      e.r   = mrow - 1;
      e.c   = mcol - 1;
      e.sof = (mrow == 2 && mcol == 2);
      e.eol = (mcol == W - 1);
      exp_q.push_back(e);
    end
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end
  endtask

  // One clock: observe the DUT, then drive the FIFO side for the next edge.
  task automatic step(input bit rst_in);
    exp_t e;
    int   px;
    logic exp_rd;
    @(negedge clk);
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_strobe: centre (%0d,%0d) got none expected dout %0d at cycle %0d",
               e.r, e.c, e.val, e.cyc);
    end
    if (rst_prev) begin
      n_cmp++;
      if (valid_out !== 1'b0 || dout !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid_out=%b dout=%0d expected 0/0", valid_out, dout);
      end
    end
    if (valid_out === 1'b1) begin
      strobes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got dout=%0d at cycle %0d expected no strobe",
                 dout, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dout !== 8'(e.val) || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL strobe (%0d,%0d): got dout=%0d cycle %0d expected %0d cycle %0d",
                   e.r, e.c, dout, cyc, e.val, e.cyc);
        end
        obs[e.r][e.c] = int'(dout);
`ifdef GAUSS_FRAME_MARKERS_EN
        n_cmp++;
        if (sof_out !== e.sof || eol_out !== e.eol) begin
          n_fail++;
          $display("FAIL markers (%0d,%0d): got sof=%b eol=%b expected sof=%b eol=%b",
                   e.r, e.c, sof_out, eol_out, e.sof, e.eol);
        end
        if (sof_out === 1'b1) sof_cnt++;
        if (eol_out === 1'b1) eol_cnt++;
`endif
      end
    end

    rst = rst_in;
    if (rst_in) begin
      exp_q.delete();
      mrow = 0;
      mcol = 0;
    end
    fifo_valid = pending;
    if (pending) begin
      px = pix_q.pop_front();
      fifo_dout = 8'(px);
      if (!rst_in) model_accept(px);
    end else begin
      fifo_dout = 8'($urandom_range(255));
    end
    fifo_empty = (pix_q.size() == 0) || ($urandom_range(99) < gap_pct);
    #1;
    exp_rd = ~fifo_empty & ~rst_in;
    n_cmp++;
    if (fifo_rd_en !== exp_rd) begin
      n_fail++;
      $display("FAIL fifo_rd_en: got %b expected %b", fifo_rd_en, exp_rd);
    end
    pending  = exp_rd;
    rst_prev = rst_in;
  endtask

  // mode 0: constant val, 1: random, 2: zero frame with 255 at (5,10)
  task automatic push_frame(input int mode, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       pix_q.push_back(val);
          1:       pix_q.push_back(int'($urandom_range(255)));
          default: pix_q.push_back((r == 5 && c == 10) ? 255 : 0);
        endcase
  endtask

  task automatic clear_obs();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        obs[r][c] = -1;
    strobes = 0;
    sof_cnt = 0;
    eol_cnt = 0;
  endtask

  task automatic drain();
    int budget;
    budget = 20 * W * H;
    while ((pix_q.size() > 0 || pending || exp_q.size() > 0) && budget > 0) begin
      step(1'b0);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pixels / %0d strobes pending expected 0",
               pix_q.size(), exp_q.size());
    end
    repeat (4) step(1'b0);
  endtask

  task automatic test_reset();
    push_frame(0, 7);
    repeat (5) step(1'b1);
    pix_q.delete();
    step(1'b0);
    step(1'b0);
  endtask

  task automatic test_constant();
    clear_obs();
    gap_pct = 0;
    push_frame(0, 100);
    drain();
    n_cmp++;
    if (strobes != NOUT) begin
      n_fail++;
      $display("FAIL const_count: got %0d expected %0d", strobes, NOUT);
    end
    n_cmp++;
    if (obs[1][1] != 100 || obs[H-2][W-2] != 100) begin
      n_fail++;
      $display("FAIL const_value: got %0d/%0d expected 100", obs[1][1], obs[H-2][W-2]);
    end
`ifdef GAUSS_FRAME_MARKERS_EN
    n_cmp++;
    if (sof_cnt != 1 || eol_cnt != H - 2) begin
      n_fail++;
      $display("FAIL marker_count: got sof=%0d eol=%0d expected 1/%0d", sof_cnt, eol_cnt, H - 2);
    end
`endif
  endtask

  task automatic test_impulse();
    int dr, dc, want;
    clear_obs();
    gap_pct = 0;
    push_frame(2, 0);
    drain();
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        dr = (r > 5) ? r - 5 : 5 - r;
        dc = (c > 10) ? c - 10 : 10 - c;
        if (dr == 0 && dc == 0)       want = 64;
        else if (dr + dc == 1)        want = 32;
        else if (dr == 1 && dc == 1)  want = 16;
        else                          want = 0;
        n_cmp++;
        if (obs[r][c] != want) begin
          n_fail++;
          $display("FAIL impulse (%0d,%0d): got %0d expected %0d", r, c, obs[r][c], want);
        end
      end
  endtask

  task automatic test_gaps();
    clear_obs();
    gap_pct = 40;
    push_frame(0, 100);
    drain();
    n_cmp++;
    if (strobes != NOUT) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d expected %0d", strobes, NOUT);
    end
  endtask

  task automatic test_random();
    clear_obs();
    gap_pct = 25;
    push_frame(1, 0);
    drain();
    n_cmp++;
    if (strobes != NOUT) begin
      n_fail++;
      $display("FAIL random_count: got %0d expected %0d", strobes, NOUT);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    gap_pct = 0;
    push_frame(0, 200);
    push_frame(0, 50);
    drain();
    n_cmp++;
    if (strobes != 2 * NOUT) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected %0d", strobes, 2 * NOUT);
    end
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c += 4) begin
        n_cmp++;
        if (obs[r][c] != 50) begin
          n_fail++;
          $display("FAIL b2b_frame2 (%0d,%0d): got %0d expected 50", r, c, obs[r][c]);
        end
      end
  endtask

  task automatic test_reset_mid();
    int budget;
    clear_obs();
    gap_pct = 10;
    push_frame(0, 100);
    budget = 20 * W * H;
    while (!(mrow == 3 && mcol == 7) && budget > 0) begin
      step(1'b0);
      budget--;
    end
    repeat (3) step(1'b1);
    pix_q.delete();
    clear_obs();
    push_frame(0, 100);
    drain();
    n_cmp++;
    if (strobes != NOUT) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d expected %0d", strobes, NOUT);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    cyc        = 0;
    gap_pct    = 0;
    pending    = 1'b0;
    rst_prev   = 1'b0;
    mrow       = 0;
    mcol       = 0;
    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    fifo_dout  = 8'd0;
    clear_obs();
    test_reset();
    test_constant();
    test_impulse();
    test_gaps();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
